// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - Instruction fetch sequencer between the PC and decode
//
// Latches the PC as the fetch address, runs a req/ack read to program memory,
// captures the returned word in the instruction register, pulses the PC
// increment, and offers the instruction to decode with a valid/ready handshake.
//
// Parameters:
//   DATA_W          instruction / memory data width
//   ADDR_W          memory address width (matches PC width)
//   TIMEOUT_CYCLES  REQ cycles without mem_ack before giving up (1..255);
//                   only used when FETCH_TIMEOUT_EN is defined
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   fetch_en   permit starting a new fetch
//   pc_in      current PC value
//   pc_inc     one-cycle PC increment strobe (combinational)
//   mem_addr   registered fetch address
//   mem_req    registered read request
//   mem_ack    one-cycle read completion, mem_rdata valid with it
//   mem_rdata  instruction word from memory
//   ir_out     instruction register
//   ir_valid   ir_out holds an unconsumed instruction
//   ir_ready   decode accepts ir_out this cycle
//   flush      discard the held or in-flight instruction
//   busy       sequencer not idle
//   fetch_err  sticky fetch timeout flag (0 unless FETCH_TIMEOUT_EN)
//
// Optional feature macro: FETCH_TIMEOUT_EN

module fetch_unit #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              pc_inc,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] ir_out,
    output logic              ir_valid,
    input  logic              ir_ready,
    input  logic              flush,
    output logic              busy,
    output logic              fetch_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    generate
        if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
            $error("fetch_unit: TIMEOUT_CYCLES must be in 1..255");
        end
    endgenerate

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic              mem_req_d;
    logic [DATA_W-1:0] ir_out_d;
    logic              ir_valid_d;
    // Set when a flush arrives while the read is still outstanding; the
    // returning data is then thrown away instead of being loaded.
    logic              drop_q, drop_d;
    logic              start_ok;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;

    assign start_ok  = fetch_en & ~err_q;
    assign fetch_err = err_q;
`else
    assign start_ok  = fetch_en;
    assign fetch_err = 1'b0;
`endif

    assign busy = (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr;
        mem_req_d  = mem_req;
        ir_out_d   = ir_out;
        ir_valid_d = ir_valid;
        drop_d     = drop_q;
        pc_inc     = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_d      = err_q;
`endif

        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    mem_addr_d = pc_in;
                    mem_req_d  = 1'b1;
                    drop_d     = 1'b0;
                    state_d    = REQ;
`ifdef FETCH_TIMEOUT_EN
                    cnt_d      = 8'd0;
`endif
                end
            end

            REQ: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    drop_d    = 1'b0;
                    // A flush in the ack cycle itself also discards the word.
                    if (drop_q || flush) begin
                        state_d = IDLE;
                    end else begin
                        ir_out_d   = mem_rdata;
                        ir_valid_d = 1'b1;
                        pc_inc     = rst;
                        state_d    = HOLD;
                    end
                end else begin
                    if (flush) begin
                        drop_d = 1'b1;
                    end
`ifdef FETCH_TIMEOUT_EN
                    // This cycle brings the count to TIMEOUT_CYCLES.
                    if (cnt_q == TIMEOUT_LAST) begin
                        err_d     = 1'b1;
                        mem_req_d = 1'b0;
                        drop_d    = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
`endif
                end
            end

            HOLD: begin
                if (flush) begin
                    ir_valid_d = 1'b0;
                    state_d    = IDLE;
                end else if (ir_ready) begin
                    ir_valid_d = 1'b0;
                    if (fetch_en) begin
                        // pc_in was incremented on the edge that loaded ir_out.
                        mem_addr_d = pc_in;
                        mem_req_d  = 1'b1;
                        drop_d     = 1'b0;
                        state_d    = REQ;
`ifdef FETCH_TIMEOUT_EN
                        cnt_d      = 8'd0;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            mem_addr <= '0;
            mem_req  <= 1'b0;
            ir_out   <= '0;
            ir_valid <= 1'b0;
            drop_q   <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            cnt_q    <= 8'd0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            mem_addr <= mem_addr_d;
            mem_req  <= mem_req_d;
            ir_out   <= ir_out_d;
            ir_valid <= ir_valid_d;
            drop_q   <= drop_d;
`ifdef FETCH_TIMEOUT_EN
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`endif
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch sequencer between the program counter and the decode/control stage of the 16-bit SAP core. It latches the current PC value as the memory address, runs a req/ack read to program memory, captures the returned word in the instruction register, and pulses the PC increment. It then offers the instruction to decode with a valid/ready handshake. Decode issues a flush on taken jumps, in the same cycle it drives the PC's write strobe.

## Interface
- `DATA_W`, 16: instruction and memory data width.
- `ADDR_W`, 16: memory address width; matches PC output width.
- `TIMEOUT_CYCLES`, 15: maximum REQ cycles without `mem_ack`. Used only with `FETCH_TIMEOUT_EN`; legal range 1..255.

Ports:
- `clk` in 1: single clock; all state changes on rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `fetch_en` in 1: permits starting a new fetch; 0 = halt after the current instruction.
- `pc_in` in ADDR_W: current PC value.
- `pc_inc` out 1: one-cycle increment strobe to the PC; combinational.
- `mem_addr` out ADDR_W: registered fetch address.
- `mem_req` out 1: registered read request.
- `mem_ack` in 1: one-cycle read completion; `mem_rdata` is valid in the same cycle.
- `mem_rdata` in DATA_W: instruction word from memory.
- `ir_out` out DATA_W: instruction register.
- `ir_valid` out 1: `ir_out` holds an unconsumed instruction.
- `ir_ready` in 1: decode accepts `ir_out` this cycle.
- `flush` in 1: one-cycle pulse that discards the held or in-flight instruction.
- `busy` out 1: state is not IDLE.
- `fetch_err` out 1: sticky fetch timeout flag; constant 0 without the macro.

## Operation
- States: IDLE, REQ, HOLD.
- IDLE:
  - If `fetch_en`=1: `mem_addr` ← `pc_in`, `mem_req` ← 1, go to REQ.
- REQ:
  - `mem_req` and `mem_addr` hold stable until `mem_ack` arrives.
  - On `mem_ack` with no pending drop: `ir_out` ← `mem_rdata`, `ir_valid` ← 1, `pc_inc`=1 in that cycle, `mem_req` ← 0, go to HOLD.
  - On `mem_ack` with a pending drop (flush seen during this REQ, including in the ack cycle): data discarded, `pc_inc`=0, drop cleared, `mem_req` ← 0, go to IDLE.
  - A REQ in flight is never aborted by `flush`; the memory transaction always completes.
- HOLD:
  - `flush`=1: `ir_valid` ← 0, go to IDLE. `flush` has priority over `ir_ready`.
  - `ir_ready`=1 with `fetch_en`=1: handshake. `ir_valid` ← 0, `mem_addr` ← `pc_in` (already incremented), `mem_req` ← 1, go to REQ.
  - `ir_ready`=1 with `fetch_en`=0: `ir_valid` ← 0, go to IDLE.
- `ir_out` keeps its last value when `ir_valid`=0.
- `fetch_en` dropping in REQ or HOLD does not cancel the current fetch; it only blocks the next one.
- `mem_ack` outside REQ is ignored.

## Timing
- All outputs are 0 after reset, and state is IDLE.
- Reset asserted mid-fetch clears state asynchronously and drops `mem_req` immediately. `pc_inc` is 0 while `rst`=0.
- `mem_req` rises 1 cycle after `fetch_en` is sampled high in IDLE.
- With a zero-wait memory (ack in the first REQ cycle), `ir_valid` rises 2 edges after the IDLE start.
- Sustained throughput is 1 instruction per 2 cycles with `ir_ready` held high.
- The PC increments on the same edge that loads `ir_out`, so `pc_in` is updated by the time the next address is latched.
- A `flush` coinciding with a PC write loads the jump target. The next fetch, from IDLE, uses that target.

## Configuration
- `FETCH_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entering REQ and increments on each REQ cycle without `mem_ack`.
  - When the counter reaches `TIMEOUT_CYCLES`: `fetch_err` ← 1 (sticky until reset), `mem_req` ← 0, go to IDLE.
  - While `fetch_err`=1, no new fetch starts.
- Not defined: no counter, `fetch_err` is constant 0, and REQ waits for `mem_ack` indefinitely.

## Test plan
- Reset, then `fetch_en`=1, `pc_in`=0x0005, ack in the first REQ cycle with `mem_rdata`=0xA3C1 → `mem_addr`=0x0005, `ir_out`=0xA3C1, `ir_valid`=1, a single `pc_inc` pulse on the ack cycle.
- `ir_ready` held 1 with zero-wait memory over PC 0x0000..0x0003 → 4 instructions in 8 cycles, addresses sequential, 4 `pc_inc` pulses.
- Memory acks after 3 wait cycles → `mem_addr` and `mem_req` stable for all 4 REQ cycles, `ir_valid` rises after the ack.
- `flush` pulse during REQ (before the ack) → ack consumed, `ir_valid` stays 0, no `pc_inc`. The next fetch uses the new `pc_in`=0x0040.
- `flush` together with `ir_ready`=1 in HOLD → instruction dropped (no handshake), state IDLE, `ir_valid`=0.
- `FETCH_TIMEOUT_EN` defined, `TIMEOUT_CYCLES`=15, no ack → `mem_req` falls and `fetch_err`=1 after 15 REQ cycles; no further `mem_req` until reset. `rst`=0 clears `fetch_err`.
